// File: rtl/sim_jtag_tap.sv
// JTAG TAP and RISC-V debug transport for simulation. The JTAG pins are oversampled in the
// system clock domain. The TAP drives IDCODE/DTMCS/DMI/BYPASS and a valid/ready DMI port.
module sim_jtag_tap #(
   parameter int unsigned IR_WIDTH = 5,
   parameter logic [31:0] IDCODE   = 32'h1000_0A6D,
   parameter int unsigned ABITS    = 7
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             jtag_TCK,
   input  logic             jtag_TMS,
   input  logic             jtag_TDI,
   input  logic             jtag_TRSTn,
   output logic             jtag_TDO_data,
   output logic             jtag_TDO_driven,
   output logic             dmi_req_valid,
   input  logic             dmi_req_ready,
   output logic [ABITS-1:0] dmi_req_addr,
   output logic [31:0]      dmi_req_data,
   output logic [1:0]       dmi_req_op,
   input  logic             dmi_resp_valid,
   output logic             dmi_resp_ready,
   input  logic [31:0]      dmi_resp_data,
   input  logic [1:0]       dmi_resp_op
);

   localparam int unsigned DMI_W = ABITS + 34;
   localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(5'h01);
   localparam logic [IR_WIDTH-1:0] IR_DTMCS  = IR_WIDTH'(5'h10);
   localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'(5'h11);

   typedef enum logic [3:0] {
      ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAUSE_DR, ST_EX2_DR,
      ST_UPD_DR, ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAUSE_IR, ST_EX2_IR, ST_UPD_IR
   } tap_state_t;

   typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_t;

   logic tck_s, tms_s, tdi_s, trstn_s, tck_d;
   logic tck_rise, tck_fall, tap_act;

   tap_state_t state, state_next;
   dr_sel_t    dr_sel;

   logic [IR_WIDTH-1:0] ir, ir_shift;
   logic [DMI_W-1:0]    dr_shift, dr_shifted, dr_capture;
   logic [31:0]         dtmcs_cap, resp_data_q;
   logic [1:0]          sticky, dmistat, upd_op;
   logic                outstanding;
   logic                cap_dmi, upd_dmi, upd_dtmcs, hard_reset, resp_fire;

   // NOTE: sequential state uses <= so every register samples pre-edge values, regardless of block order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tck_s   <= 1'b0;
         tms_s   <= 1'b0;
         tdi_s   <= 1'b0;
         trstn_s <= 1'b0;
         tck_d   <= 1'b0;
      end else begin
         tck_s   <= jtag_TCK;
         tms_s   <= jtag_TMS;
         tdi_s   <= jtag_TDI;
         trstn_s <= jtag_TRSTn;
         tck_d   <= tck_s;
      end
   end

   assign tck_rise = tck_s & ~tck_d;
   assign tck_fall = ~tck_s & tck_d;
   assign tap_act  = tck_rise & trstn_s;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_TLR;
      else          state <= state_next;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      if (!trstn_s) begin
         state_next = ST_TLR;
      end else if (tck_rise) begin
         case (state)
            ST_TLR:      state_next = tms_s ? ST_TLR      : ST_RTI;
            ST_RTI:      state_next = tms_s ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_next = tms_s ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_next = tms_s ? ST_EX1_DR   : ST_SH_DR;
            ST_SH_DR:    state_next = tms_s ? ST_EX1_DR   : ST_SH_DR;
            ST_EX1_DR:   state_next = tms_s ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_next = tms_s ? ST_EX2_DR   : ST_PAUSE_DR;
            ST_EX2_DR:   state_next = tms_s ? ST_UPD_DR   : ST_SH_DR;
            ST_UPD_DR:   state_next = tms_s ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_next = tms_s ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_next = tms_s ? ST_EX1_IR   : ST_SH_IR;
            ST_SH_IR:    state_next = tms_s ? ST_EX1_IR   : ST_SH_IR;
            ST_EX1_IR:   state_next = tms_s ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_next = tms_s ? ST_EX2_IR   : ST_PAUSE_IR;
            ST_EX2_IR:   state_next = tms_s ? ST_UPD_IR   : ST_SH_IR;
            ST_UPD_IR:   state_next = tms_s ? ST_SEL_DR   : ST_RTI;
            default:     state_next = ST_TLR;
         endcase
      end
   end

   always_comb begin
      case (ir)
         IR_IDCODE: dr_sel = DR_IDCODE;
         IR_DTMCS:  dr_sel = DR_DTMCS;
         IR_DMI:    dr_sel = DR_DMI;
         default:   dr_sel = DR_BYPASS;
      endcase
   end

   assign dmistat   = (sticky != 2'd0) ? sticky : (outstanding ? 2'd3 : 2'd0);
   assign dtmcs_cap = {14'b0, 2'b0, 1'b0, 3'd1, dmistat, 6'(ABITS), 4'd1};

   always_comb begin
      case (dr_sel)
         DR_IDCODE: dr_capture = DMI_W'(IDCODE);
         DR_DTMCS:  dr_capture = DMI_W'(dtmcs_cap);
         DR_DMI:    dr_capture = {dmi_req_addr, resp_data_q, dmistat};
         default:   dr_capture = '0;
      endcase
   end

   // One physical shift register serves every DR; TDI enters at the MSB of the selected length.
   always_comb begin
      dr_shifted = dr_shift >> 1;
      case (dr_sel)
         DR_DMI:    dr_shifted[DMI_W-1] = tdi_s;
         DR_BYPASS: dr_shifted = {{(DMI_W-1){1'b0}}, tdi_s};
         default:   dr_shifted[31] = tdi_s;
      endcase
   end

   // NOTE: the shift registers are plain flops rather than memories, so they are reset like any other state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ir       <= IR_IDCODE;
         ir_shift <= '0;
         dr_shift <= '0;
      end else if (!trstn_s) begin
         ir <= IR_IDCODE;
      end else if (tck_rise) begin
         case (state)
            ST_TLR:    ir       <= IR_IDCODE;
            ST_CAP_IR: ir_shift <= IR_WIDTH'(1);
            ST_SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
            ST_UPD_IR: ir       <= ir_shift;
            ST_CAP_DR: dr_shift <= dr_capture;
            ST_SH_DR:  dr_shift <= dr_shifted;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         jtag_TDO_data   <= 1'b0;
         jtag_TDO_driven <= 1'b0;
      end else if (tck_fall && trstn_s) begin
         jtag_TDO_data   <= (state == ST_SH_IR) ? ir_shift[0] : dr_shift[0];
         jtag_TDO_driven <= (state == ST_SH_IR) || (state == ST_SH_DR);
      end
   end

   assign cap_dmi    = tap_act && (state == ST_CAP_DR) && (dr_sel == DR_DMI);
   assign upd_dmi    = tap_act && (state == ST_UPD_DR) && (dr_sel == DR_DMI);
   assign upd_dtmcs  = tap_act && (state == ST_UPD_DR) && (dr_sel == DR_DTMCS);
   assign hard_reset = upd_dtmcs && dr_shift[17];
   assign resp_fire  = dmi_resp_valid && outstanding && !hard_reset;
   assign upd_op     = dr_shift[1:0];
   assign dmi_resp_ready = outstanding;

   // Later statements take priority: busy and hardreset handling override the response path.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dmi_req_valid <= 1'b0;
         dmi_req_addr  <= '0;
         dmi_req_data  <= '0;
         dmi_req_op    <= '0;
         resp_data_q   <= '0;
         outstanding   <= 1'b0;
         sticky        <= 2'd0;
      end else begin
         if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;
         if (resp_fire) begin
            resp_data_q <= dmi_resp_data;
            outstanding <= 1'b0;
            if (sticky == 2'd0 && dmi_resp_op[1]) sticky <= dmi_resp_op;
         end
         if (cap_dmi && outstanding) sticky <= 2'd3;
         if (upd_dmi) begin
            if (outstanding) begin
               sticky <= 2'd3;
            end else if ((upd_op[0] ^ upd_op[1]) && sticky == 2'd0) begin
               dmi_req_valid <= 1'b1;
               dmi_req_addr  <= dr_shift[DMI_W-1:34];
               dmi_req_data  <= dr_shift[33:2];
               dmi_req_op    <= upd_op;
               outstanding   <= 1'b1;
            end
         end
         if (upd_dtmcs && (dr_shift[16] || dr_shift[17])) sticky <= 2'd0;
         if (hard_reset) begin
            dmi_req_valid <= 1'b0;
            outstanding   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sim_jtag_tap.sv
// Bench for sim_jtag_tap: drives JTAG scans at pin level and compares captured DR contents and
// DMI traffic against a transaction-level model of the debug transport.
module tb_sim_jtag_tap;

   localparam int ABITS = 7;
   localparam int DMI_W = ABITS + 34;
   localparam logic [31:0] IDCODE = 32'h1000_0A6D;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic tck = 1'b0, tms = 1'b1, tdi = 1'b0, trstn = 1'b1;
   logic tdo, tdo_drv;
   logic req_valid, req_ready = 1'b0;
   logic [ABITS-1:0] req_addr;
   logic [31:0] req_data;
   logic [1:0] req_op;
   logic resp_valid = 1'b0, resp_ready;
   logic [31:0] resp_data = '0;
   logic [1:0] resp_op = '0;

   int n_tests = 0;
   int n_fail = 0;

   // Transaction-level model of the debug transport
   logic [ABITS-1:0] m_addr = '0;
   logic [31:0] m_resp = '0;
   logic [1:0] m_sticky = '0;
   logic m_out = 1'b0;
   logic m_valid = 1'b0;

   sim_jtag_tap #(.IR_WIDTH(5), .IDCODE(IDCODE), .ABITS(ABITS)) dut (
      .clock(clock), .reset_n(reset_n),
      .jtag_TCK(tck), .jtag_TMS(tms), .jtag_TDI(tdi), .jtag_TRSTn(trstn),
      .jtag_TDO_data(tdo), .jtag_TDO_driven(tdo_drv),
      .dmi_req_valid(req_valid), .dmi_req_ready(req_ready),
      .dmi_req_addr(req_addr), .dmi_req_data(req_data), .dmi_req_op(req_op),
      .dmi_resp_valid(resp_valid), .dmi_resp_ready(resp_ready),
      .dmi_resp_data(resp_data), .dmi_resp_op(resp_op)
   );

   always #5 clock = ~clock;

   initial begin
      #700000;
      $display("FAIL watchdog: time limit reached, got no summary, expected completion");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] m_dmistat();
      if (m_sticky != 2'd0) return m_sticky;
      return m_out ? 2'd3 : 2'd0;
   endfunction

   // One TCK period; returns TDO as updated by the falling edge.
   task automatic tick(input logic t_ms, input logic t_di, output logic o_tdo, output logic o_drv);
      @(negedge clock);
      tms = t_ms; tdi = t_di; tck = 1'b1;
      repeat (4) @(negedge clock);
      tck = 1'b0;
      repeat (4) @(negedge clock);
      o_tdo = tdo; o_drv = tdo_drv;
   endtask

   task automatic tap_reset();
      logic o, d;
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, o, d);
      tick(1'b0, 1'b0, o, d);
      check("rti_driven", 64'(d), 64'(0));
   endtask

   task automatic scan_ir(input logic [4:0] code);
      logic o, d;
      logic [4:0] cap;
      logic drv_ok;
      drv_ok = 1'b1; cap = '0;
      tick(1'b1, 1'b0, o, d); tick(1'b1, 1'b0, o, d); tick(1'b0, 1'b0, o, d);
      if (d) drv_ok = 1'b0;
      tick(1'b0, 1'b0, o, d);
      cap[0] = o;
      if (!d) drv_ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(i == 4, code[i], o, d);
         if (i < 4) begin
            cap[i+1] = o;
            if (!d) drv_ok = 1'b0;
         end else if (d) drv_ok = 1'b0;
      end
      tick(1'b1, 1'b0, o, d); tick(1'b0, 1'b0, o, d);
      check("ir_capture", 64'(cap), 64'(5'h01));
      check("ir_driven", 64'(drv_ok), 64'(1));
   endtask

   task automatic scan_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
      logic o, d;
      logic drv_ok;
      dout = '0; drv_ok = 1'b1;
      tick(1'b1, 1'b0, o, d); tick(1'b0, 1'b0, o, d);
      if (d) drv_ok = 1'b0;
      tick(1'b0, 1'b0, o, d);
      dout[0] = o;
      if (!d) drv_ok = 1'b0;
      for (int i = 0; i < len; i++) begin
         tick(i == len - 1, din[i], o, d);
         if (i < len - 1) begin
            dout[i+1] = o;
            if (!d) drv_ok = 1'b0;
         end else if (d) drv_ok = 1'b0;
      end
      tick(1'b1, 1'b0, o, d); tick(1'b0, 1'b0, o, d);
      check("dr_driven", 64'(drv_ok), 64'(1));
   endtask

   task automatic dmi_scan(input logic [ABITS-1:0] a, input logic [31:0] dd, input logic [1:0] op,
                           output logic issued);
      logic [63:0] dout;
      logic [DMI_W-1:0] exp_cap;
      exp_cap = {m_addr, m_resp, m_dmistat()};
      scan_dr(DMI_W, 64'({a, dd, op}), dout);
      check("dmi_capture", dout, 64'(exp_cap));
      if (m_out) m_sticky = 2'd3;
      issued = 1'b0;
      if (m_out) m_sticky = 2'd3;
      else if ((op == 2'd1 || op == 2'd2) && m_sticky == 2'd0) begin
         issued = 1'b1; m_out = 1'b1; m_valid = 1'b1; m_addr = a;
      end
      check("dmi_port_state", 64'({req_valid, resp_ready}), 64'({m_valid, m_out}));
   endtask

   task automatic dtmcs_scan(input logic [31:0] v);
      logic [63:0] dout;
      logic [31:0] exp_cap;
      exp_cap = 32'h0000_1071 | (32'(m_dmistat()) << 10);
      scan_dr(32, 64'(v), dout);
      check("dtmcs_capture", dout, 64'(exp_cap));
      if (v[16] || v[17]) m_sticky = 2'd0;
      if (v[17]) begin m_out = 1'b0; m_valid = 1'b0; end
      check("dtmcs_port_state", 64'({req_valid, resp_ready}), 64'({m_valid, m_out}));
   endtask

   task automatic req_handshake(input logic [ABITS-1:0] a, input logic [31:0] dd, input logic [1:0] op,
                                input int hold);
      int k;
      k = 0;
      while (!req_valid && k < 20) begin @(negedge clock); k++; end
      check("req_valid", 64'(req_valid), 64'(1));
      check("req_payload", 64'({req_addr, req_data, req_op}), 64'({a, dd, op}));
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         check("req_hold", 64'({req_valid, req_addr, req_data, req_op}), 64'({1'b1, a, dd, op}));
      end
      req_ready = 1'b1;
      @(negedge clock);
      req_ready = 1'b0;
      m_valid = 1'b0;
      check("req_drop", 64'(req_valid), 64'(0));
   endtask

   task automatic respond(input logic [31:0] dd, input logic [1:0] op);
      int k;
      k = 0;
      while (!resp_ready && k < 20) begin @(negedge clock); k++; end
      check("resp_ready", 64'(resp_ready), 64'(1));
      resp_valid = 1'b1; resp_data = dd; resp_op = op;
      @(negedge clock);
      resp_valid = 1'b0;
      check("resp_ready_clr", 64'(resp_ready), 64'(0));
      m_resp = dd; m_out = 1'b0;
      if (m_sticky == 2'd0 && op >= 2'd2) m_sticky = op;
   endtask

   initial begin
      logic [63:0] dout, din, mask;
      logic iss, o, d;
      logic [4:0] code;
      logic [ABITS-1:0] a;
      logic [31:0] dd;
      logic [1:0] op;
      int len, r;

      repeat (3) @(negedge clock);
      check("reset_tdo", 64'({tdo, tdo_drv}), 64'(0));
      check("reset_dmi", 64'({req_valid, resp_ready, req_addr, req_data, req_op}), 64'(0));
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // IDCODE is the default DR after TAP reset
      tap_reset();
      scan_dr(32, 64'($urandom), dout);
      check("idcode", dout, 64'(IDCODE));

      // BYPASS: directed 1,0,1,1 then unknown IR codes with random patterns
      scan_ir(5'h1F);
      scan_dr(4, 64'(4'b1101), dout);
      check("bypass_1011", dout, 64'(4'b1010));
      for (int i = 0; i < 4; i++) begin
         do code = 5'($urandom); while (code == 5'h01 || code == 5'h10 || code == 5'h11);
         len = $urandom_range(2, 16);
         din = {$urandom, $urandom};
         mask = (64'd1 << len) - 64'd1;
         scan_ir(code);
         scan_dr(len, din, dout);
         check("bypass_rand", dout & mask, (din << 1) & mask);
      end

      // DTMCS capture at idle
      scan_ir(5'h10);
      dtmcs_scan(32'h0);

      // DMI read with stalled ready, then response
      scan_ir(5'h11);
      dmi_scan(7'h10, 32'h0, 2'd1, iss);
      if (iss) req_handshake(7'h10, 32'h0, 2'd1, 3);
      respond(32'hCAFE_F00D, 2'd0);
      dmi_scan(7'h00, 32'h0, 2'd0, iss);

      // Busy update, then dmireset once the response is in
      dd = $urandom;
      dmi_scan(7'h22, dd, 2'd2, iss);
      if (iss) req_handshake(7'h22, dd, 2'd2, 0);
      dmi_scan(7'h23, $urandom, 2'd1, iss);
      scan_ir(5'h10);
      dtmcs_scan(32'h0);
      respond($urandom, 2'd0);
      dtmcs_scan(32'h0001_0000);
      dtmcs_scan(32'h0);

      // dmihardreset while the request is still presented
      scan_ir(5'h11);
      dd = $urandom;
      dmi_scan(7'h30, dd, 2'd1, iss);
      scan_ir(5'h10);
      dtmcs_scan(32'h0002_0000);
      dtmcs_scan(32'h0);

      // Randomised DMI traffic
      scan_ir(5'h11);
      for (int it = 0; it < 16; it++) begin
         a = 7'($urandom); dd = $urandom; op = 2'($urandom_range(0, 3));
         dmi_scan(a, dd, op, iss);
         if (iss) begin
            req_handshake(a, dd, op, $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) dmi_scan(7'($urandom), $urandom, 2'($urandom_range(0, 3)), iss);
            repeat ($urandom_range(0, 5)) @(negedge clock);
            r = $urandom_range(0, 3);
            respond($urandom, (r < 2) ? 2'd0 : 2'(r));
         end
         if (m_sticky != 2'd0 && $urandom_range(0, 1) == 1) begin
            scan_ir(5'h10);
            dtmcs_scan(32'h0001_0000);
            scan_ir(5'h11);
         end
      end

      // TRSTn in the middle of a bypass shift
      scan_ir(5'h1F);
      tick(1'b1, 1'b0, o, d); tick(1'b0, 1'b0, o, d); tick(1'b0, 1'b1, o, d);
      tick(1'b0, 1'b1, o, d); tick(1'b0, 1'b0, o, d);
      @(negedge clock); trstn = 1'b0;
      repeat (4) @(negedge clock); trstn = 1'b1;
      repeat (4) @(negedge clock);
      tick(1'b0, 1'b0, o, d);
      check("trst_driven", 64'(d), 64'(0));
      scan_dr(32, 64'($urandom), dout);
      check("trst_idcode", dout, 64'(IDCODE));

      // reset_n while a request is presented
      scan_ir(5'h10);
      dtmcs_scan(32'h0003_0000);
      scan_ir(5'h11);
      dmi_scan(7'h5A, 32'h1234_5678, 2'd2, iss);
      @(negedge clock); reset_n = 1'b0;
      #1;
      check("rst_pulse_out", 64'({tdo, tdo_drv, req_valid, resp_ready, req_addr, req_data, req_op}), 64'(0));
      m_addr = '0; m_resp = '0; m_sticky = '0; m_out = 1'b0; m_valid = 1'b0;
      @(negedge clock); reset_n = 1'b1;
      repeat (2) @(negedge clock);
      tap_reset();
      scan_dr(32, 64'($urandom), dout);
      check("post_rst_idcode", dout, 64'(IDCODE));
      scan_ir(5'h11);
      dmi_scan(7'h00, 32'h0, 2'd0, iss);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
